// File: rtl/sample_rate_meter_if.sv
// -----------------------------------------------------------------------------
// sample_rate_meter_if
//   Bundles the control, strobe and result signals of sample_rate_meter.
//   master : the side driving controls and ready strobes (e.g. XADC wrapper/host)
//   slave  : the meter itself
//
//   enable      measurement enable; low forces the meter idle
//   single_shot 1 = one window per start, 0 = continuous windows
//   start       single-shot trigger, level sampled while idle
//   ready       per-channel ready / end-of-conversion strobes
//   rate        latched counts, channel i at [i*CNT_W +: CNT_W]
//   rate_valid  one-cycle pulse when rate/sat update
//   sat         per-channel "count clipped in last latched window"
//   busy        high while a window is running
// -----------------------------------------------------------------------------
interface sample_rate_meter_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic                      enable;
    logic                      single_shot;
    logic                      start;
    logic [NUM_CH-1:0]         ready;
    logic [NUM_CH*CNT_W-1:0]   rate;
    logic                      rate_valid;
    logic [NUM_CH-1:0]         sat;
    logic                      busy;

    modport master (
        output enable, single_shot, start, ready,
        input  rate, rate_valid, sat, busy
    );

    modport slave (
        input  enable, single_shot, start, ready,
        output rate, rate_valid, sat, busy
    );
endinterface

// File: rtl/sample_rate_meter.sv
// -----------------------------------------------------------------------------
// sample_rate_meter
//   Counts falling edges of NUM_CH ready strobes over a gate window of
//   GATE_CYCLES clock cycles and latches the per-channel counts at the end of
//   each window, pulsing rate_valid for one cycle. Counters saturate at
//   2^CNT_W-1 and report clipping through per-channel sat flags. Supports
//   continuous and single-shot operation; dropping enable aborts a window
//   without touching the previously latched results.
//
//   clk100  : system clock, all logic on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : sample_rate_meter_if.slave (controls, strobes, results)
// -----------------------------------------------------------------------------
module sample_rate_meter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 100000000,
    parameter int GATE_W      = 27
) (
    input  logic                 clk100,
    input  logic                 reset_n,
    sample_rate_meter_if.slave   bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [GATE_W-1:0] LAST_GATE = GATE_W'(GATE_CYCLES - 1);

    state_t                   r_state;
    logic [GATE_W-1:0]        r_gate_cnt;
    logic [NUM_CH-1:0]        r_ready_d;
    logic                     r_rate_valid;
    logic                     r_busy;

    logic [NUM_CH-1:0]        w_fall;
    logic                     w_run;
    logic                     w_last;
    logic                     w_count;
    logic [NUM_CH*CNT_W-1:0]  w_rate_flat;
    logic [NUM_CH-1:0]        w_sat_flat;

    // ready_d tracks in every state so the first RUN cycle sees a true history
    assign w_fall  = r_ready_d & ~bus.ready;
    assign w_run   = (r_state == S_RUN);
    assign w_last  = w_run && (r_gate_cnt == LAST_GATE);
    // Ordinary accumulating cycle: running, not the window end, not aborting
    assign w_count = w_run && bus.enable && !w_last;

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_d <= '0;
        end else begin
            r_ready_d <= bus.ready;
        end
    end

    // Window sequencing; busy is registered alongside the state
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_gate_cnt   <= '0;
            r_rate_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rate_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_gate_cnt <= '0;
                    if (bus.enable && (!bus.single_shot || bus.start)) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        // Window end wins over an enable drop on the same cycle
                        r_gate_cnt   <= '0;
                        r_rate_valid <= 1'b1;
                        if (bus.single_shot || !bus.enable) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (!bus.enable) begin
                        r_gate_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_rate;
            logic             r_sat_acc;
            logic             r_sat;
            logic             w_at_max;
            logic             w_hit;
            logic [CNT_W-1:0] w_cnt_next;

            assign w_at_max   = &r_cnt;
            assign w_hit      = w_fall[gi] & w_at_max;
            assign w_cnt_next = (w_fall[gi] && !w_at_max) ? (r_cnt + CNT_W'(1)) : r_cnt;

            always_ff @(posedge clk100 or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt     <= '0;
                    r_rate    <= '0;
                    r_sat_acc <= 1'b0;
                    r_sat     <= 1'b0;
                end else if (w_last) begin
                    // Latch includes the edge (and any clipping) of the last gate cycle
                    r_rate    <= w_cnt_next;
                    r_sat     <= r_sat_acc | w_hit;
                    r_cnt     <= '0;
                    r_sat_acc <= 1'b0;
                end else if (w_count) begin
                    r_cnt     <= w_cnt_next;
                    r_sat_acc <= r_sat_acc | w_hit;
                end else begin
                    // Idle, abort, and the IDLE->RUN transition cycle count nothing
                    r_cnt     <= '0;
                    r_sat_acc <= 1'b0;
                end
            end

            assign w_rate_flat[gi*CNT_W +: CNT_W] = r_rate;
            assign w_sat_flat[gi]                 = r_sat;
        end
    endgenerate

    assign bus.rate       = w_rate_flat;
    assign bus.sat        = w_sat_flat;
    assign bus.rate_valid = r_rate_valid;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_sample_rate_meter.sv
// -----------------------------------------------------------------------------
// tb_sample_rate_meter
//   Directed sequence with randomized ready traffic. The bench records every
//   ready value the meter samples and derives expected counts by counting
//   falling edges over the 20 sample pairs that belong to each window.
// -----------------------------------------------------------------------------
module tb_sample_rate_meter;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 3;
    localparam int GATE   = 20;
    localparam int CMAX   = 7;

    logic clk100 = 1'b0;
    logic reset_n;

    sample_rate_meter_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    sample_rate_meter #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE), .GATE_W(5)
    ) u_dut (
        .clk100 (clk100),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk100 = ~clk100;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         win_t = 0;
    logic [1:0] hist [0:4095];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int rate_of(input int ch);
        logic [CNT_W-1:0] v;
        v = bus.rate[ch*CNT_W +: CNT_W];
        return 32'(v);
    endfunction

    // Drive ready for the next edge, record it, and sample 2 time units after
    task automatic tick(input logic [1:0] rdy);
        bus.ready      = rdy;
        hist[cyc + 1]  = rdy;
        @(posedge clk100);
        #2;
        cyc++;
    endtask

    // Falling edges of channel ch seen in the window whose transition edge is t
    function automatic int falls(input int ch, input int t);
        int n = 0;
        for (int j = 0; j < GATE; j++)
            if (hist[t + j][ch] && !hist[t + j + 1][ch]) n++;
        return n;
    endfunction

    // Ready value driven in window cycle j for each stimulus mode
    function automatic logic [1:0] pat(input int mode, input int j);
        case (mode)
            0:       return {1'b0, ((j % 4) < 2)};   // period 4, high first
            1:       return 2'($urandom);
            2:       return {1'b0, ((j % 2) == 0)};  // toggle every cycle
            4:       return {1'b0, (j == 18)};       // one fall in last gate cycle
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_window_result();
        int n;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            n = falls(ch, win_t);
            chk($sformatf("rate%0d", ch), rate_of(ch), (n > CMAX) ? CMAX : n);
            chk($sformatf("sat%0d", ch), 32'(bus.sat[ch]), (n > CMAX) ? 1 : 0);
        end
    endtask

    // From idle (or aborting a run): one enable-low cycle, a transition cycle,
    // then nwin continuous windows; leaves the meter running at gate 0.
    task automatic run_windows(input int nwin, input logic [11:0] modes, input logic [1:0] pre);
        int mode;
        bus.enable = 1'b0;
        tick(pre);
        chk("pre_busy", 32'(bus.busy), 0);
        chk("pre_valid", 32'(bus.rate_valid), 0);
        bus.enable      = 1'b1;
        bus.single_shot = 1'b0;
        bus.start       = 1'b0;
        tick(2'b00);
        win_t = cyc;
        chk("go_busy", 32'(bus.busy), 1);
        for (int w = 0; w < nwin; w++) begin
            mode = 32'(modes[3*w +: 3]);
            for (int j = 0; j < GATE; j++) begin
                tick(pat(mode, j));
                chk("run_valid", 32'(bus.rate_valid), (j == GATE - 1) ? 1 : 0);
                chk("run_busy", 32'(bus.busy), 1);
            end
            check_window_result();
            win_t = cyc;
        end
    endtask

    task automatic abort_tick();
        bus.enable = 1'b0;
        tick(2'b00);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_valid", 32'(bus.rate_valid), 0);
    endtask

    initial begin
        int busy_cnt;
        int rv_cnt;
        int saved0;

        // Power-on reset
        reset_n         = 1'b0;
        bus.enable      = 1'b0;
        bus.single_shot = 1'b0;
        bus.start       = 1'b0;
        bus.ready       = 2'b00;
        tick(2'b00);
        tick(2'b00);
        chk("rst_rate", 32'(bus.rate), 0);
        chk("rst_sat", 32'(bus.sat), 0);
        chk("rst_valid", 32'(bus.rate_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset_n = 1'b1;

        // Idle with traffic: nothing happens
        for (int k = 0; k < 5; k++) begin
            tick(2'($urandom));
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_valid", 32'(bus.rate_valid), 0);
        end

        // Continuous, period-4 ready[0], ready[1] quiet
        run_windows(3, {3'd0, 3'd0, 3'd0}, 2'b00);
        chk("cont_rate0_lit", rate_of(0), 5);
        chk("cont_rate1_lit", rate_of(1), 0);

        // Abort at gate cycle 10: results hold
        for (int j = 0; j < 10; j++) begin
            tick(pat(0, j));
            chk("pre_abort_valid", 32'(bus.rate_valid), 0);
        end
        bus.enable = 1'b0;
        tick(pat(0, 10));
        chk("abort10_busy", 32'(bus.busy), 0);
        chk("abort10_valid", 32'(bus.rate_valid), 0);
        chk("abort10_rate0", rate_of(0), 5);
        for (int k = 0; k < 3; k++) begin
            tick(2'($urandom));
            chk("post_abort_valid", 32'(bus.rate_valid), 0);
            chk("post_abort_rate0", rate_of(0), 5);
        end

        // Fresh windows after re-enable: random, random, then period-4
        run_windows(3, {3'd0, 3'd1, 3'd1}, 2'b00);
        chk("rand_tail_rate0_lit", rate_of(0), 5);

        // Asynchronous reset mid-window with ready toggling
        for (int k = 0; k < 5; k++) tick(2'($urandom));
        reset_n = 1'b0;
        #1;
        chk("arst_rate", 32'(bus.rate), 0);
        chk("arst_sat", 32'(bus.sat), 0);
        chk("arst_valid", 32'(bus.rate_valid), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        bus.enable = 1'b0;
        tick(2'($urandom));
        tick(2'($urandom));
        reset_n = 1'b1;

        // Single fall in the last gate cycle counts
        run_windows(1, {3'd0, 3'd0, 3'd4}, 2'b00);
        chk("edge_last_lit", rate_of(0), 1);

        // Single fall in the IDLE->RUN transition cycle does not count
        run_windows(1, {3'd0, 3'd0, 3'd3}, 2'b01);
        chk("edge_trans_lit", rate_of(0), 0);

        // Saturation window, then a quiet window clears it
        run_windows(2, {3'd0, 3'd3, 3'd2}, 2'b00);
        chk("sat_clear_rate0", rate_of(0), 0);
        chk("sat_clear_sat0", 32'(bus.sat[0]), 0);
        abort_tick();

        // Same saturation window checked on its own result
        run_windows(1, {3'd0, 3'd0, 3'd2}, 2'b00);
        chk("sat_rate0_lit", rate_of(0), 7);
        chk("sat_sat0_lit", 32'(bus.sat[0]), 1);
        abort_tick();
        chk("sat_hold", 32'(bus.sat[0]), 1);

        // Single shot with a one-cycle start pulse
        bus.enable      = 1'b1;
        bus.single_shot = 1'b1;
        bus.start       = 1'b1;
        tick(2'b00);
        win_t    = cyc;
        bus.start = 1'b0;
        busy_cnt = bus.busy ? 1 : 0;
        rv_cnt   = 0;
        saved0   = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(2'($urandom));
            if (bus.busy) busy_cnt++;
            if (bus.rate_valid) rv_cnt++;
            chk("ss_valid", 32'(bus.rate_valid), (k == GATE) ? 1 : 0);
            chk("ss_busy", 32'(bus.busy), (k < GATE) ? 1 : 0);
            if (k == GATE) begin
                check_window_result();
                saved0 = rate_of(0);
            end
        end
        chk("ss_busy_cycles", busy_cnt, GATE);
        chk("ss_valid_count", rv_cnt, 1);
        chk("ss_rate_hold", rate_of(0), saved0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_rate_meter.md
Name: sample_rate_meter

Overview:
- Measures the event rate of NUM_CH independent ready/end-of-conversion strobes, such as XADC eoc, over a programmable gate window.
- Counts falling edges of each ready input in the clk100 domain and latches per-channel counts at each gate end. Raises a one-cycle valid strobe with each latch.
- Supports continuous and single-shot measurement, saturating counters with per-channel saturation flags, and abort on enable drop.
- Sits between the XADC wrapper and the display/readout logic.

Parameters:
- NUM_CH, 4: number of monitored ready channels (1..16).
- CNT_W, 16: per-channel count width in bits.
- GATE_CYCLES, 100000000: gate window length in clk100 cycles (≥2); one second at 100 MHz.
- GATE_W, 27: gate counter width; must satisfy 2^GATE_W > GATE_CYCLES.

Ports:
- clk100 in 1: system clock; all logic rises on posedge.
- reset_n in 1: asynchronous active-low reset.
- enable in 1: measurement enable; low forces IDLE.
- single_shot in 1: 1 = one window per start; 0 = continuous windows.
- start in 1: single-shot trigger; level sampled in IDLE; ignored when single_shot=0.
- ready in NUM_CH: per-channel strobes, synchronous to clk100.
- rate out NUM_CH*CNT_W: latched counts; channel i occupies bits [i*CNT_W +: CNT_W].
- rate_valid out 1: one-cycle pulse when rate/sat update.
- sat out NUM_CH: per-channel flag; count clipped in the last latched window.
- busy out 1: high while in RUN.

Behaviour:
- Async reset (reset_n=0): state=IDLE, gate_cnt=0, all channel counters=0, ready_d=0, rate=0, sat=0, rate_valid=0, busy=0.
- Edge detect: ready_d[i] is registered every cycle in all states. fall[i] = ready_d[i] & ~ready[i]. Because ready_d tracks continuously, entering RUN never produces a false edge.
- IDLE:
  - busy=0; gate_cnt and channel counters held at 0.
  - Go to RUN when enable=1 and (single_shot=0 or start=1).
- RUN:
  - busy=1. The first RUN cycle has gate_cnt=0; gate_cnt increments each cycle.
  - fall[i] in any RUN cycle, including the first and last, increments cnt[i].
  - Fall edges in the IDLE→RUN transition cycle are not counted.
  - Counters saturate at 2^CNT_W-1; a fall while at max sets sat_acc[i].
- Window end (RUN and gate_cnt==GATE_CYCLES-1):
  - Next cycle: rate[i] = cnt[i] plus fall[i] from this last cycle (saturating); sat[i] = sat_acc[i], including saturation caused by the last-cycle edge; rate_valid=1 for exactly one cycle.
  - Same edge: gate_cnt, cnt and sat_acc clear to 0.
  - Next state: IDLE if single_shot=1 or enable=0; otherwise RUN, starting a new window with no gap cycle.
- Abort: enable=0 in RUN before the last gate cycle → IDLE next cycle. No latch, no rate_valid; rate and sat hold their previous values.
- single_shot changed mid-window: takes effect at that window's end only.
- start held high in single-shot mode: a new window begins on the cycle after returning to IDLE, giving back-to-back windows with one IDLE cycle between them.
- rate and sat change only on rate_valid cycles or reset.
- Latency: the last edge counted is in gate cycle GATE_CYCLES-1; the result is visible one cycle later.

Test Plan:
- Reset: assert reset_n=0 mid-simulation with ready toggling → rate=0, sat=0, rate_valid=0, busy=0 immediately (asynchronous); rate_valid stays 0 after release until a full window completes.
- Continuous (GATE_CYCLES=20, NUM_CH=2):
  - Stimulus: enable=1, single_shot=0; ready[0] at period 4 (2 high/2 low, rising on the first RUN cycle); ready[1] held 0.
  - Required: rate_valid every 20 cycles; rate[0]=5, rate[1]=0, sat=0.
- Saturation (CNT_W=3, GATE_CYCLES=20): ready[0] toggles every cycle (10 falls/window) → rate[0]=7, sat[0]=1. The next window, with ready[0]=0, gives rate[0]=0 and sat[0]=0.
- Boundary edge: a single fall on ready[0] in gate cycle 19 → rate[0]=1. A single fall in the IDLE→RUN transition cycle → rate[0]=0.
- Single shot: single_shot=1, start pulsed for 1 cycle → busy high for exactly 20 cycles, one rate_valid, then IDLE; no further rate_valid until the next start.
- Abort: enable dropped at gate cycle 10 after a prior result of rate[0]=5 → busy=0 next cycle, no rate_valid, rate[0] stays 5. Re-enabling starts a fresh 20-cycle window.
